// File: rtl/barrier_rx_filter_if.sv
// barrier_rx_filter_if: rx metadata stream, rx data stream and token output
// of the barrier receive filter, bundled for port connection.
//
// Handshake rule for every stream here: a transfer happens on a rising clk
// edge where valid and ready are both 1. A source holds valid and its payload
// stable until that transfer, and never waits for ready before raising valid.
//
// Modports: slave = the filter (consumes rx streams, sources tokens);
//           master = the environment (sources rx streams, consumes tokens).
interface barrier_rx_filter_if #(
  parameter int DATA_W = 512
) ();
  logic              s_rx_meta_valid;
  logic              s_rx_meta_ready;
  logic [47:0]       s_rx_meta_data;
  logic              s_rx_data_valid;
  logic              s_rx_data_ready;
  logic [DATA_W-1:0] s_rx_data_data;
  logic              s_rx_data_last;
  logic              m_token_valid;
  logic              m_token_ready;
  logic [2:0]        m_token_src;

  modport slave (
    input  s_rx_meta_valid, s_rx_meta_data,
    output s_rx_meta_ready,
    input  s_rx_data_valid, s_rx_data_data, s_rx_data_last,
    output s_rx_data_ready,
    output m_token_valid, m_token_src,
    input  m_token_ready
  );

  modport master (
    output s_rx_meta_valid, s_rx_meta_data,
    input  s_rx_meta_ready,
    output s_rx_data_valid, s_rx_data_data, s_rx_data_last,
    input  s_rx_data_ready,
    input  m_token_valid, m_token_src,
    output m_token_ready
  );
endinterface

// File: rtl/barrier_rx_filter.sv
// barrier_rx_filter: turns token packets from known peer sessions into
// per-peer pending-token counts and presents them round-robin on a
// valid/ready token output. Non-token packets are drained and dropped.
// Optional macro BARRIER_FILTER_STAT_EN adds stat_accepted / stat_dropped.
module barrier_rx_filter #(
  parameter int          NUM_NODES = 8,
  parameter int          CNT_W     = 4,
  parameter int          DATA_W    = 512,
  parameter logic [31:0] TOKEN_PAT = 32'hFFFF_FFFF
) (
  input  logic                   clk,
  input  logic                   rstn,
  barrier_rx_filter_if.slave     bus,
  input  logic [NUM_NODES*16-1:0] session_table,
  input  logic                   enable,
  output logic                   overflow,
  input  logic                   clear,
  output logic [1:0]             dbg_state
`ifdef BARRIER_FILTER_STAT_EN
  ,
  output logic [31:0]            stat_accepted,
  output logic [31:0]            stat_dropped
`endif
);

  typedef enum logic [1:0] {S_META = 2'd0, S_FIRST = 2'd1, S_DRAIN = 2'd2} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic             meta_rdy, data_rdy;
  logic             hit_q;
  logic [2:0]       idx_q;
  logic             inc_valid;
  logic [2:0]       inc_idx;
  logic [CNT_W-1:0] cnt     [NUM_NODES];
  logic [CNT_W-1:0] cnt_nxt [NUM_NODES];
  logic             tv;
  logic [2:0]       tsrc;
  logic [2:0]       rr;

  logic             hit_c;
  logic [2:0]       idx_c;
  logic             meta_hs, data_hs, first_hs, tok_c, tok_hs;
  logic             sat_c;
  logic [NUM_NODES-1:0] pend;
  logic [2:0]       base;
  logic             pick_valid;
  logic [2:0]       pick_src;

  // Length field and data above the pattern word carry nothing for us.
  logic unused_bits;
  assign unused_bits = ^{bus.s_rx_meta_data[47:16], bus.s_rx_data_data[DATA_W-1:32]};

  assign bus.s_rx_meta_ready = meta_rdy;
  assign bus.s_rx_data_ready = data_rdy;
  assign bus.m_token_valid   = tv;
  assign bus.m_token_src     = tsrc;
  assign dbg_state           = state;

  assign meta_hs  = meta_rdy & bus.s_rx_meta_valid;
  assign data_hs  = data_rdy & bus.s_rx_data_valid;
  assign first_hs = data_hs & (state == S_FIRST);
  assign tok_c    = hit_q & (bus.s_rx_data_data[31:0] == TOKEN_PAT);
  assign tok_hs   = tv & bus.m_token_ready;

  // Session lookup; descending scan so the lowest matching index wins.
  always_comb begin
    hit_c = 1'b0;
    idx_c = '0;
    for (int i = NUM_NODES - 1; i >= 0; i--) begin
      if (session_table[i*16 +: 16] == bus.s_rx_meta_data[15:0]) begin
        hit_c = 1'b1;
        idx_c = 3'(i);
      end
    end
  end

  // Rx packet FSM: classify on metadata, judge the first beat, drain the rest.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_META;
      meta_rdy  <= 1'b0;
      data_rdy  <= 1'b0;
      hit_q     <= 1'b0;
      idx_q     <= '0;
      inc_valid <= 1'b0;
      inc_idx   <= '0;
    end else begin
      inc_valid <= 1'b0;
      case (state)
        S_META: begin
          meta_rdy <= 1'b1;
          data_rdy <= 1'b0;
          if (meta_hs) begin
            hit_q    <= enable & hit_c;
            idx_q    <= idx_c;
            meta_rdy <= 1'b0;
            data_rdy <= 1'b1;
            state    <= S_FIRST;
          end
        end
        S_FIRST: begin
          if (data_hs) begin
            inc_valid <= tok_c;
            inc_idx   <= idx_q;
            if (bus.s_rx_data_last) begin
              state    <= S_META;
              data_rdy <= 1'b0;
              meta_rdy <= 1'b1;
            end else begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (data_hs && bus.s_rx_data_last) begin
            state    <= S_META;
            data_rdy <= 1'b0;
            meta_rdy <= 1'b1;
          end
        end
        default: begin
          state    <= S_META;
          meta_rdy <= 1'b0;
          data_rdy <= 1'b0;
        end
      endcase
    end
  end

  // Next counter values: clear dominates; inc and dec on one slot cancel.
  always_comb begin
    logic inc_i, dec_i;
    sat_c = 1'b0;
    inc_i = 1'b0;
    dec_i = 1'b0;
    for (int i = 0; i < NUM_NODES; i++) begin
      cnt_nxt[i] = cnt[i];
      inc_i = inc_valid && (inc_idx == 3'(i));
      dec_i = tok_hs && (tsrc == 3'(i));
      if (clear) begin
        cnt_nxt[i] = '0;
      end else if (inc_i && !dec_i) begin
        if (cnt[i] == CNT_MAX) sat_c = 1'b1;
        else                   cnt_nxt[i] = cnt[i] + 1'b1;
      end else if (dec_i && !inc_i) begin
        cnt_nxt[i] = cnt[i] - 1'b1;
      end
    end
  end

  // Round-robin pick over slots still pending after this cycle's handshake.
  // Increments landing this cycle are deliberately not seen until next cycle.
  always_comb begin
    logic [2:0] j;
    base       = tok_hs ? 3'((int'(tsrc) + 1) % NUM_NODES) : rr;
    pick_valid = 1'b0;
    pick_src   = base;
    j          = '0;
    for (int i = 0; i < NUM_NODES; i++) begin
      pend[i] = (tok_hs && (tsrc == 3'(i))) ? (cnt[i] > CNT_W'(1)) : (cnt[i] != '0);
    end
    for (int k = NUM_NODES - 1; k >= 0; k--) begin
      j = 3'((int'(base) + k) % NUM_NODES);
      if (pend[j]) begin
        pick_valid = 1'b1;
        pick_src   = j;
      end
    end
  end

  // Counters, sticky overflow, rr pointer and the held token output.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_NODES; i++) cnt[i] <= '0;
      overflow <= 1'b0;
      tv       <= 1'b0;
      tsrc     <= '0;
      rr       <= '0;
    end else begin
      for (int i = 0; i < NUM_NODES; i++) cnt[i] <= cnt_nxt[i];
      overflow <= clear ? 1'b0 : (overflow | sat_c);
      if (tok_hs) rr <= 3'((int'(tsrc) + 1) % NUM_NODES);
      if (clear) begin
        tv <= 1'b0;
      end else if (!tv || tok_hs) begin
        tv <= pick_valid;
        if (pick_valid) tsrc <= pick_src;
      end
    end
  end

`ifdef BARRIER_FILTER_STAT_EN
  // Wrapping statistics; a saturated token counts as a dropped packet.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_accepted <= '0;
      stat_dropped  <= '0;
    end else if (clear) begin
      stat_accepted <= '0;
      stat_dropped  <= '0;
    end else begin
      if (inc_valid && !sat_c) stat_accepted <= stat_accepted + 32'd1;
      stat_dropped <= stat_dropped + 32'(first_hs && !tok_c) + 32'(sat_c);
    end
  end
`endif

endmodule

// File: tb/tb_barrier_rx_filter.sv
// tb_barrier_rx_filter: directed bench for barrier_rx_filter with a token
// scoreboard (exp_q) and hand-computed expectations.
module tb_barrier_rx_filter;

  localparam int NUM_NODES = 8;
  localparam int DATA_W    = 512;

  // Clock / reset
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [NUM_NODES*16-1:0] session_table;
  logic                    enable;
  logic                    overflow;
  logic                    clear;
  logic [1:0]              dbg_state;
`ifdef BARRIER_FILTER_STAT_EN
  logic [31:0]             stat_accepted;
  logic [31:0]             stat_dropped;
`endif

  barrier_rx_filter_if #(.DATA_W(DATA_W)) bus ();

  barrier_rx_filter #(
    .NUM_NODES(NUM_NODES), .CNT_W(4), .DATA_W(DATA_W), .TOKEN_PAT(32'hFFFF_FFFF)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus),
    .session_table(session_table),
    .enable(enable),
    .overflow(overflow),
    .clear(clear),
    .dbg_state(dbg_state)
`ifdef BARRIER_FILTER_STAT_EN
    ,
    .stat_accepted(stat_accepted),
    .stat_dropped(stat_dropped)
`endif
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver tasks: all start and end on a falling clock edge.
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_meta(input logic [15:0] sess);
    int n = 0;
    bus.s_rx_meta_valid = 1'b1;
    bus.s_rx_meta_data  = {32'd64, sess};
    while (!bus.s_rx_meta_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("meta_hs", 32'(bus.s_rx_meta_ready), 32'd1);
    @(negedge clk);
    bus.s_rx_meta_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] w, input logic last);
    int n = 0;
    bus.s_rx_data_valid        = 1'b1;
    bus.s_rx_data_data         = '0;
    bus.s_rx_data_data[31:0]   = w;
    bus.s_rx_data_data[63:32]  = $urandom_range(32'hFFFF_FFFF, 0);
    bus.s_rx_data_last         = last;
    while (!bus.s_rx_data_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("data_hs", 32'(bus.s_rx_data_ready), 32'd1);
    @(negedge clk);
    bus.s_rx_data_valid = 1'b0;
    bus.s_rx_data_last  = 1'b0;
  endtask

  task automatic send_pkt(input logic [15:0] sess, input logic [31:0] w, input int beats);
    send_meta(sess);
    for (int b = 0; b < beats; b++) send_beat((b == 0) ? w : 32'hFFFF_FFFF, b == beats - 1);
  endtask

  // Scoreboard: consume tokens for a bounded window and match against exp_q.
  task automatic collect(input int cycles);
    bus.m_token_ready = 1'b1;
    repeat (cycles) begin
      if (bus.m_token_valid) begin
        if (exp_q.size() == 0) check("extra_token", 32'(bus.m_token_src), 32'hDEAD);
        else                   check("token_src", 32'(bus.m_token_src), exp_q.pop_front());
      end
      @(negedge clk);
    end
    bus.m_token_ready = 1'b0;
    check("missing_tokens", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] tbl [NUM_NODES];
    tbl = '{16'h0010, 16'h0011, 16'h0022, 16'h0012, 16'h0012, 16'h0050, 16'h0060, 16'h0070};
    for (int i = 0; i < NUM_NODES; i++) session_table[i*16 +: 16] = tbl[i];
    rstn = 1'b0; enable = 1'b1; clear = 1'b0;
    bus.s_rx_meta_valid = 1'b0; bus.s_rx_meta_data = '0;
    bus.s_rx_data_valid = 1'b0; bus.s_rx_data_data = '0; bus.s_rx_data_last = 1'b0;
    bus.m_token_ready = 1'b0;

    // Reset values
    wait_cyc(3);
    check("rst_meta_ready", 32'(bus.s_rx_meta_ready), 32'd0);
    check("rst_data_ready", 32'(bus.s_rx_data_ready), 32'd0);
    check("rst_valid", 32'(bus.m_token_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rstn = 1'b1;
    wait_cyc(2);

    // Single token for idx 3 (idx 4 duplicates the session; lowest wins), 2-cycle latency
    send_meta(16'h0012);
    send_beat(32'hFFFF_FFFF, 1'b1);
    check("lat_c0_valid", 32'(bus.m_token_valid), 32'd0);
    wait_cyc(1);
    check("lat_c1_valid", 32'(bus.m_token_valid), 32'd0);
    wait_cyc(1);
    check("lat_c2_valid", 32'(bus.m_token_valid), 32'd1);
    check("lat_c2_src", 32'(bus.m_token_src), 32'd3);
    exp_q.push_back(32'd3);
    collect(6);
    check("t1_valid_low", 32'(bus.m_token_valid), 32'd0);

    // Unknown session, 3 beats: all drained, no token
    send_pkt(16'h0099, 32'hFFFF_FFFF, 3);
    check("unk_state_meta", 32'(dbg_state), 32'd0);
    wait_cyc(4);
    check("unk_no_token", 32'(bus.m_token_valid), 32'd0);
`ifdef BARRIER_FILTER_STAT_EN
    check("unk_stat_dropped", stat_dropped, 32'd1);
`endif

    // Pattern mismatch then a real token: exactly one out
    send_pkt(16'h0012, 32'h0000_0001, 1);
    wait_cyc(4);
    check("mis_no_token", 32'(bus.m_token_valid), 32'd0);
    send_pkt(16'h0012, 32'hFFFF_FFFF, 1);
    exp_q.push_back(32'd3);
    collect(10);
`ifdef BARRIER_FILTER_STAT_EN
    check("mis_stat_acc", stat_accepted, 32'd2);
    check("mis_stat_drop", stat_dropped, 32'd2);
`endif

    // Saturation: 16 tokens to idx 5 with ready low, 15 come out
    for (int i = 0; i < 16; i++) send_pkt(16'h0050, 32'hFFFF_FFFF, 1);
    wait_cyc(3);
    check("sat_overflow", 32'(overflow), 32'd1);
    check("sat_valid", 32'(bus.m_token_valid), 32'd1);
    check("sat_src", 32'(bus.m_token_src), 32'd5);
    for (int i = 0; i < 15; i++) exp_q.push_back(32'd5);
    collect(40);
    check("sat_overflow_sticky", 32'(overflow), 32'd1);
`ifdef BARRIER_FILTER_STAT_EN
    check("sat_stat_acc", stat_accepted, 32'd17);
    check("sat_stat_drop", stat_dropped, 32'd3);
`endif

    // Round robin: 7 held while 6,1,2 arrive -> 7,1,2,6
    send_pkt(16'h0070, 32'hFFFF_FFFF, 1);
    wait_cyc(3);
    send_pkt(16'h0060, 32'hFFFF_FFFF, 1);
    send_pkt(16'h0011, 32'hFFFF_FFFF, 1);
    send_pkt(16'h0022, 32'hFFFF_FFFF, 1);
    wait_cyc(3);
    check("rr_hold_src", 32'(bus.m_token_src), 32'd7);
    exp_q = '{32'd7, 32'd1, 32'd2, 32'd6};
    collect(20);

    // Round robin: 2 held while 6,1 arrive -> rr=3 after 2 -> 2,6,1
    send_pkt(16'h0022, 32'hFFFF_FFFF, 1);
    wait_cyc(3);
    send_pkt(16'h0011, 32'hFFFF_FFFF, 1);
    send_pkt(16'h0060, 32'hFFFF_FFFF, 1);
    wait_cyc(3);
    exp_q = '{32'd2, 32'd6, 32'd1};
    collect(20);

    // enable=0 drops the packet; dropping enable after metadata keeps the hit
    enable = 1'b0;
    send_pkt(16'h0012, 32'hFFFF_FFFF, 1);
    collect(8);
    enable = 1'b1;
    send_meta(16'h0012);
    enable = 1'b0;
    send_beat(32'hFFFF_FFFF, 1'b1);
    enable = 1'b1;
    exp_q.push_back(32'd3);
    collect(10);

    // clear with 4 tokens pending while held
    send_pkt(16'h0010, 32'hFFFF_FFFF, 1);
    send_pkt(16'h0010, 32'hFFFF_FFFF, 1);
    send_pkt(16'h0050, 32'hFFFF_FFFF, 1);
    send_pkt(16'h0050, 32'hFFFF_FFFF, 1);
    wait_cyc(3);
    check("clr_pre_valid", 32'(bus.m_token_valid), 32'd1);
    check("clr_pre_overflow", 32'(overflow), 32'd1);
`ifdef BARRIER_FILTER_STAT_EN
    check("clr_pre_stat_acc", stat_accepted, 32'd29);
    check("clr_pre_stat_drop", stat_dropped, 32'd4);
`endif
    clear = 1'b1;
    wait_cyc(1);
    clear = 1'b0;
    check("clr_valid", 32'(bus.m_token_valid), 32'd0);
    check("clr_overflow", 32'(overflow), 32'd0);
`ifdef BARRIER_FILTER_STAT_EN
    check("clr_stat_acc", stat_accepted, 32'd0);
    check("clr_stat_drop", stat_dropped, 32'd0);
`endif
    collect(10);

    // Async reset in the middle of DRAIN with a token presented
    send_pkt(16'h0010, 32'hFFFF_FFFF, 1);
    wait_cyc(3);
    check("drn_valid", 32'(bus.m_token_valid), 32'd1);
    send_meta(16'h0010);
    send_beat(32'hFFFF_FFFF, 1'b0);
    check("drn_state", 32'(dbg_state), 32'd2);
    #1 rstn = 1'b0;
    #1;
    check("arst_state", 32'(dbg_state), 32'd0);
    check("arst_meta_ready", 32'(bus.s_rx_meta_ready), 32'd0);
    check("arst_data_ready", 32'(bus.s_rx_data_ready), 32'd0);
    check("arst_valid", 32'(bus.m_token_valid), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    wait_cyc(2);
    send_pkt(16'h0012, 32'hFFFF_FFFF, 1);
    exp_q.push_back(32'd3);
    collect(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/barrier_rx_filter.md
Name: barrier_rx_filter

Overview:
- Sits directly upstream of the barrier engine, between the TCP receive path (rx metadata + rx data streams) and the barrier token input.
- Classifies each received packet by session: a packet from a known peer session whose first word is the token pattern becomes one pending token for that peer index; anything else is drained and dropped.
- Holds per-peer saturating token counters and presents pending tokens one at a time, round-robin, on a valid/ready token output.

Parameters:
- NUM_NODES, 8, number of peer session slots (power of two, max 8)
- CNT_W, 4, width of each per-peer pending-token counter
- DATA_W, 512, rx data beat width
- TOKEN_PAT, 32'hFFFF_FFFF, token pattern expected in data[31:0] of first beat

Ports:
- clk  in  1  user clock
- rstn  in  1  asynchronous active-low reset
- s_rx_meta_valid  in  1  rx metadata valid
- s_rx_meta_ready  out  1  rx metadata ready
- s_rx_meta_data  in  48  [15:0] session id, [47:16] length in bytes (ignored)
- s_rx_data_valid  in  1  rx data valid
- s_rx_data_ready  out  1  rx data ready
- s_rx_data_data  in  DATA_W  rx data beat
- s_rx_data_last  in  1  last beat of packet
- session_table  in  NUM_NODES*16  peer session id per index, static while enable=1
- enable  in  1  filter enable; 0 = drop everything
- m_token_valid  out  1  a pending token is presented
- m_token_ready  in  1  barrier consumes token
- m_token_src  out  3  peer index of presented token
- overflow  out  1  sticky: a token arrived at a saturated counter
- clear  in  1  synchronous pulse: zero all counters and overflow

Behaviour:
- Reset (rstn=0, async): state=META, all counters 0, rr pointer 0, overflow 0, m_token_valid 0, s_rx_meta_ready 0, s_rx_data_ready 0, match regs 0.
- FSM:
  - META: s_rx_meta_ready=1, s_rx_data_ready=0. On meta handshake, register hit = enable AND some session_table[i]==session (lowest i wins on duplicates); register idx=i. Go to FIRST.
  - FIRST: s_rx_data_ready=1. On data handshake, token = hit AND data[31:0]==TOKEN_PAT. If last=1, go to META, else go to DRAIN.
  - DRAIN: s_rx_data_ready=1. Discard beats. On a handshake with last=1, go to META.
- Token increment: occurs in the cycle after the FIRST handshake with token=1. If counter[idx] == 2^CNT_W-1, the counter holds and overflow sets. Packets without a hit, or with pattern mismatch, only drain and never touch counters.
- Output:
  - m_token_valid is registered: it is 1 when any counter is nonzero and the selection is stable.
  - Selection is round-robin starting at the rr pointer. It is recomputed only when no token is presented or after a handshake.
  - m_token_src and m_token_valid are held stable while valid=1 and ready=0.
  - On a handshake: counter[src] decrements, and rr pointer = src+1 (mod NUM_NODES).
- Simultaneous increment and decrement on the same counter in one cycle: net unchanged. A saturated counter therefore does not set overflow in that case.
- Latency: token beat handshake to m_token_valid (from idle) = 2 cycles.
- clear: has priority over increment and decrement. It zeroes counters and overflow and forces m_token_valid=0 next cycle. It does not disturb the rx FSM.
- enable=0 mid-packet: the hit already registered for that packet stands. Existing counters remain drainable.
- A beat with last=1 arriving in META is impossible, because data ready is 0 in META; the rx path must not hang on it.

Optional Feature:
- BARRIER_FILTER_STAT_EN defined:
  - Adds outputs stat_accepted[31:0] (tokens counted) and stat_dropped[31:0] (packets drained without a token, including saturated ones).
  - Both are wrapping counters, reset to 0, and zeroed by clear.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- session_table[3]=16'h0012, enable=1: send meta session 0x12 plus one beat data[31:0]=FFFF_FFFF, last=1 -> 2 cycles later m_token_valid=1, m_token_src=3; after ready, counter is 0 and valid falls.
- Meta session 0x99 (absent) plus 3 beats -> all beats accepted, no token, FSM back in META. With the macro on, stat_dropped=1.
- Session match but data[31:0]=0000_0001 -> no token. Then a token packet for index 3 -> exactly 1 token out.
- Hold m_token_ready=0 and send 16 tokens for idx 5 (CNT_W=4) -> counter saturates at 15 and overflow=1. Release ready -> exactly 15 tokens with src=5.
- Tokens pending for idx 1, 2, 6 with ready=1 -> output order 1, 2, 6. With rr=3 and pending at 1 and 6 -> order 6, 1.
- Pulse clear with 4 tokens pending while valid=1 and ready=0 -> next cycle valid=0, overflow=0, and no further tokens appear. Assert rstn low mid-DRAIN -> immediate return to reset values.
